// File: rtl/scan_sequencer_2to4_if.sv
// Handshake/control bundle between a scan controller and scan_sequencer_2to4.
// The sequencer's enable/sel outputs feed decoder_2to4 directly.
interface scan_sequencer_2to4_if #(
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               continuous;
    logic [3:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic               enable;
    logic [1:0]         sel;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, continuous, ch_mask, dwell,
        input  enable, sel, busy, done
    );

    modport slave (
        input  start, stop, continuous, ch_mask, dwell,
        output enable, sel, busy, done
    );
endinterface

// File: rtl/scan_sequencer_2to4.sv
// Channel scanner for decoder_2to4: walks the set bits of a latched mask in
// ascending order, holding each channel for dwell+1 cycles, single-shot or looping.
module scan_sequencer_2to4 #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    scan_sequencer_2to4_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_nxt;
    logic [3:0]         mask_q, mask_nxt;
    logic               cont_q, cont_nxt;
    logic               enable_q, enable_nxt;
    logic [1:0]         sel_q, sel_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;

    logic               dwell_hit;
    logic [3:0]         above;

    // Index of the lowest set bit; callers guarantee a non-zero mask.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Mask bits strictly above the current channel.
    function automatic logic [3:0] above_mask(input logic [3:0] m, input logic [1:0] cur);
        logic [3:0] hi;
        hi = 4'd0;
        for (int i = 0; i < 4; i++) begin
            hi[i] = m[i] && (i > int'(cur));
        end
        return hi;
    endfunction

    assign dwell_hit = (cnt == dwell_q);
    assign above     = above_mask(mask_q, sel_q);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dwell_q  <= '0;
            mask_q   <= 4'd0;
            cont_q   <= 1'b0;
            enable_q <= 1'b0;
            sel_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dwell_q  <= dwell_nxt;
            mask_q   <= mask_nxt;
            cont_q   <= cont_nxt;
            enable_q <= enable_nxt;
            sel_q    <= sel_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start && (bus.ch_mask != 4'd0)) state_nxt = SCAN;
            end
            SCAN: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (dwell_hit && (above == 4'd0) && !cont_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath next values; done is a single-cycle pulse by default.
    always_comb begin
        cnt_nxt    = cnt;
        dwell_nxt  = dwell_q;
        mask_nxt   = mask_q;
        cont_nxt   = cont_q;
        enable_nxt = enable_q;
        sel_nxt    = sel_q;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.ch_mask != 4'd0)) begin
                    mask_nxt   = bus.ch_mask;
                    dwell_nxt  = bus.dwell;
                    cont_nxt   = bus.continuous;
                    sel_nxt    = lowest_set(bus.ch_mask);
                    enable_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = '0;
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    enable_nxt = 1'b0;
                    busy_nxt   = 1'b0;
                    cnt_nxt    = '0;
                end else if (!dwell_hit) begin
                    cnt_nxt = cnt + DWELL_W'(1);
                end else begin
                    cnt_nxt = '0;
                    if (above != 4'd0) begin
                        sel_nxt = lowest_set(above);
                    end else if (cont_q) begin
                        sel_nxt = lowest_set(mask_q);
                    end else begin
                        enable_nxt = 1'b0;
                        busy_nxt   = 1'b0;
                        done_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                enable_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.enable = enable_q;
    assign bus.sel    = sel_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_scan_sequencer_2to4.sv
// Directed vector bench for scan_sequencer_2to4: a table of per-edge
// inputs/expected outputs plus hand-written dwell-length sequences.
module tb_scan_sequencer_2to4;
    localparam int unsigned DWELL_W = 8;

    typedef struct {
        logic               rst;
        logic               start;
        logic               stop;
        logic               cont;
        logic [3:0]         mask;
        logic [DWELL_W-1:0] dwell;
        logic               en;
        logic [1:0]         sel;
        logic               busy;
        logic               done;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t vecs[$];

    scan_sequencer_2to4_if #(.DWELL_W(DWELL_W)) bus ();

    scan_sequencer_2to4 #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic en, input logic [1:0] sel,
                         input logic busy, input logic done);
        n_vec++;
        if (bus.enable !== en || bus.sel !== sel || bus.busy !== busy || bus.done !== done) begin
            n_err++;
            $display("FAIL %s: got en=%b sel=%0d busy=%b done=%b, expected en=%b sel=%0d busy=%b done=%b",
                     name, bus.enable, bus.sel, bus.busy, bus.done, en, sel, busy, done);
        end
    endtask

    // Drive one vector's inputs, clock one edge, compare just after it.
    task automatic apply(input vec_t v, input int idx);
        rst            = v.rst;
        bus.start      = v.start;
        bus.stop       = v.stop;
        bus.continuous = v.cont;
        bus.ch_mask    = v.mask;
        bus.dwell      = v.dwell;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), v.en, v.sel, v.busy, v.done);
    endtask

    initial begin
        int cycles;
        logic [DWELL_W-1:0] dw_list[2];

        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_mask = 4'd0;
        bus.dwell = '0;

        // Reset, then mid-scan reset held for two edges.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'd3, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd3, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 8'd3, 1'b0, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 8'd3, 1'b0, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd3, 1'b0, 2'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd3, 1'b0, 2'd0, 1'b0, 1'b0});
        // Single-shot full scan, dwell 0.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 8'd0, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd0, 1'b1, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd0, 1'b1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd0, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd0, 1'b0, 2'd3, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 8'd0, 1'b0, 2'd3, 1'b0, 1'b0});
        // Sparse mask 1010, dwell 2, single-shot.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'hA, 8'd2, 1'b1, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b1, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b1, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b0, 2'd3, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 8'd2, 1'b0, 2'd3, 1'b0, 1'b0});
        // Empty-mask start and stop in IDLE are ignored.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd0, 1'b0, 2'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 8'd0, 1'b0, 2'd3, 1'b0, 1'b0});
        // Continuous 1001 dwell 1; mid-scan start/mask/dwell/mode changes ignored; stop on sel=3.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'h9, 8'd1, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 8'd0, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 8'd0, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'd0, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'd0, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'd0, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'd0, 1'b1, 2'd3, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 8'd0, 1'b0, 2'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 8'd0, 1'b0, 2'd3, 1'b0, 1'b0});
        // Continuous with a single set bit holds sel.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 8'd0, 1'b1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd0, 1'b1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd0, 1'b1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 8'd0, 1'b1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 8'd0, 1'b0, 2'd2, 1'b0, 1'b0});
        // Back-to-back: new start on the done cycle.
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 8'd0, 1'b1, 2'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 8'd0, 1'b0, 2'd2, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 8'd0, 1'b1, 2'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 8'd0, 1'b1, 2'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 8'd0, 1'b0, 2'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 8'd0, 1'b0, 2'd1, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Dwell length on channel 3 alone, including the full-width dwell value.
        dw_list[0] = 8'd5;
        dw_list[1] = 8'd255;
        for (int k = 0; k < 2; k++) begin
            bus.start      = 1'b1;
            bus.stop       = 1'b0;
            bus.continuous = 1'b0;
            bus.ch_mask    = 4'h8;
            bus.dwell      = dw_list[k];
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            cycles = 0;
            while (bus.enable === 1'b1 && cycles < 400) begin
                cycles++;
                @(posedge clk);
                #1;
            end
            n_vec++;
            if (cycles != int'(dw_list[k]) + 1) begin
                n_err++;
                $display("FAIL dwell%0d_len: got %0d enable cycles, expected %0d",
                         k, cycles, int'(dw_list[k]) + 1);
            end
            check($sformatf("dwell%0d_done", k), 1'b0, 2'd3, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("dwell%0d_after", k), 1'b0, 2'd3, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/scan_sequencer_2to4.md
Name: scan_sequencer_2to4

Overview:
- Sequential channel scanner that sits directly upstream of decoder_2to4 and drives its enable and 2-bit in ports.
- Steps through the channels selected by a 4-bit mask in ascending order and holds each channel for a programmable dwell time.
- Supports single-shot and continuous scanning.
- Reports busy status and emits a one-cycle done pulse when a single-shot scan finishes.

Parameters:
- DWELL_W, 8, width of the dwell field. Each channel is held for dwell+1 clock cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; sampled only in SCAN.
- continuous  input  1  1 = wrap and rescan indefinitely, 0 = single pass. Latched at start.
- ch_mask  input  4  channel visit mask, bit n = visit channel n. Latched at start.
- dwell  input  DWELL_W  hold time per channel, minus one. Latched at start.
- enable  output  1  drives decoder_2to4.enable; registered.
- sel  output  2  drives decoder_2to4.in; registered.
- busy  output  1  high while in SCAN; registered.
- done  output  1  one-cycle pulse at single-shot completion; registered.

Behaviour:
- Reset is applied at any rising edge where rst=1, including mid-scan, and overrides all other inputs. After reset:
  - state=IDLE
  - enable=0, sel=2'b00, busy=0, done=0
  - dwell counter=0
  - latched mask, dwell and mode all =0
- FSM has two states, IDLE and SCAN.
- IDLE:
  - done is cleared to 0 on every edge, unless it is being set by that same edge.
  - On an edge with start=1 and ch_mask!=0:
    - latch ch_mask, dwell and continuous
    - sel = index of the lowest set bit of ch_mask
    - enable=1, busy=1, counter=0
    - go to SCAN
  - start=1 with ch_mask=4'b0000 is ignored: the block stays in IDLE and all outputs are unchanged.
  - stop is ignored in IDLE.
- SCAN, evaluated each edge:
  - Priority: rst, then stop, then the dwell logic below.
  - stop=1: go to IDLE; enable=0, busy=0, done=0; sel holds its last value; counter=0.
  - counter!=latched dwell: counter increments by 1. Other outputs hold.
  - counter==latched dwell: counter=0, then advance to the channel chosen as follows.
    - Next channel = the lowest set bit of the latched mask strictly above sel.
    - If such a bit exists: sel = that index.
    - If none exists and the latched mode is continuous: sel = the lowest set bit (wrap).
    - If none exists and the latched mode is single-shot: go to IDLE; enable=0, busy=0, done=1 for exactly one cycle; sel holds the last channel.
  - If the mask has a single set bit in continuous mode, sel stays constant indefinitely.
  - start is ignored while in SCAN. Changes to ch_mask, dwell or continuous during SCAN have no effect.
- Timing:
  - Latency from start sampled at edge k to enable=1 with the first sel valid is the edge k itself (registered outputs).
  - Each channel occupies exactly dwell+1 cycles.
  - Single-shot: for N set mask bits, enable is high for N*(dwell+1) cycles, and done goes high on the edge that drops enable.
- A new start may be accepted on the edge after done, i.e. while done=1 and state=IDLE. That edge clears done and starts the new scan.
- Counter arithmetic is unsigned, DWELL_W bits wide, and never wraps: it resets to 0 on every channel advance.
- Outputs never glitch: enable, sel, busy and done all come from flops.

Test Plan:
- Reset: rst=1 for 2 edges mid-scan (mask 4'b1111, dwell 3) -> next cycle enable=0, sel=00, busy=0, done=0. start held at 0 afterwards -> outputs stay at reset values.
- Single-shot full scan: mask 4'b1111, dwell 0, continuous=0, start for 1 cycle ->
  - sel=0,1,2,3 on 4 consecutive cycles with enable=1, busy=1
  - on the 5th edge: enable=0, busy=0, done=1 for exactly 1 cycle, sel=3
- Sparse mask with dwell: mask 4'b1010, dwell 2, single-shot -> sel=1 for 3 cycles, then sel=3 for 3 cycles, then done pulse. Channels 0 and 2 are never driven.
- Continuous wrap and stop: mask 4'b1001, dwell 1, continuous=1 ->
  - sel sequence 0,0,3,3,0,0,3,3...
  - assert stop while sel=3 -> next edge: enable=0, busy=0, done stays 0
- Ignored inputs:
  - start with mask 4'b0000 -> no state change
  - start during SCAN -> no restart
  - ch_mask changed to 4'b0001 mid-scan -> original latched sequence continues
- Back-to-back: a second start asserted on the done cycle -> scan restarts immediately and done returns to 0 on that edge.
